// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read bus between pc_fetch_unit (master) and the
// instruction memory (slave): one-outstanding request/ack handshake.
interface pc_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch front end with a single skid entry.
// Optional feature: define PC_ALIGN_CHECK_EN for misaligned-redirect detection.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0030
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             next_pc_i,
  input  logic                    redirect_i,
  input  logic                    stall_i,
  pc_fetch_unit_if.master         imem,
  output logic                    if_valid_o,
  output logic [31:0]             if_pc_o,
  output logic [31:0]             if_instr_o,
  output logic [31:0]             if_pc_plus4_o,
  output logic                    fetch_misalign_o
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, SQUASH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [31:0] opc_q, opc_d;
  logic [31:0] oinstr_q, oinstr_d;
  logic [31:0] skpc_q, skpc_d;
  logic [31:0] skinstr_q, skinstr_d;
  logic [31:0] target;
  logic        slot_free;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign target = {next_pc_i[31:2], 2'b00};
`else
  assign target = next_pc_i;
`endif

  assign slot_free = !valid_q || !stall_i;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    req_d     = req_q;
    valid_d   = valid_q;
    opc_d     = opc_q;
    oinstr_d  = oinstr_q;
    skpc_d    = skpc_q;
    skinstr_d = skinstr_q;
`ifdef PC_ALIGN_CHECK_EN
    mis_d     = mis_q;
`endif

    // Output register drains when downstream is not stalled; loads below override.
    if (!stall_i) valid_d = 1'b0;

    if (redirect_i) begin
      pc_d      = target;
      valid_d   = 1'b0;
      skpc_d    = '0;
      skinstr_d = '0;
`ifdef PC_ALIGN_CHECK_EN
      if (next_pc_i[1:0] != 2'b00) mis_d = 1'b1;
`endif
      // An unacked request must run to completion on the old address.
      if ((state_q == REQ || state_q == SQUASH) && !imem.imem_ack_i) begin
        state_d = SQUASH;
      end else begin
        state_d = REQ;
        addr_d  = target;
        req_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        BOOT: begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
        REQ: begin
          if (imem.imem_ack_i) begin
            pc_d   = pc_q + 32'd4;
            addr_d = pc_q + 32'd4;
            if (slot_free) begin
              valid_d  = 1'b1;
              opc_d    = addr_q;
              oinstr_d = imem.imem_rdata_i;
            end else begin
              skpc_d    = addr_q;
              skinstr_d = imem.imem_rdata_i;
              req_d     = 1'b0;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            valid_d  = 1'b1;
            opc_d    = skpc_q;
            oinstr_d = skinstr_q;
            state_d  = REQ;
            req_d    = 1'b1;
            addr_d   = pc_q;
          end
        end
        SQUASH: begin
          if (imem.imem_ack_i) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      opc_q     <= RESET_PC;
      oinstr_q  <= '0;
      skpc_q    <= '0;
      skinstr_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      opc_q     <= opc_d;
      oinstr_q  <= oinstr_d;
      skpc_q    <= skpc_d;
      skinstr_q <= skinstr_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
  assign fetch_misalign_o = mis_q;
`else
  assign fetch_misalign_o = 1'b0;
`endif

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;
  assign if_valid_o       = valid_q;
  assign if_pc_o          = opc_q;
  assign if_instr_o       = oinstr_q;
  assign if_pc_plus4_o    = opc_q + 32'd4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc_i;
  logic        redirect_i;
  logic        stall_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_plus4_o;
  logic        fetch_misalign_o;

  int unsigned n_cmp;
  int unsigned n_err;

  pc_fetch_unit_if imem_bus();

  pc_fetch_unit #(.RESET_PC(32'h0040_0030)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .next_pc_i        (next_pc_i),
    .redirect_i       (redirect_i),
    .stall_i          (stall_i),
    .imem             (imem_bus),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .if_instr_o       (if_instr_o),
    .if_pc_plus4_o    (if_pc_plus4_o),
    .fetch_misalign_o (fetch_misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem(input logic ack, input logic [31:0] data);
    imem_bus.imem_ack_i   = ack;
    imem_bus.imem_rdata_i = data;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    next_pc_i = '0;
    redirect_i = 1'b0;
    stall_i = 1'b0;
    mem(1'b0, '0);
    tick(); tick();

    check("rst_req",    32'(imem_bus.imem_req_o), 32'd0);
    check("rst_valid",  32'(if_valid_o),          32'd0);
    check("rst_addr",   imem_bus.imem_addr_o,     32'h0040_0030);
    check("rst_pc",     if_pc_o,                  32'h0040_0030);
    check("rst_instr",  if_instr_o,               32'h0);
    check("rst_mis",    32'(fetch_misalign_o),    32'd0);

    // Reset release, zero-wait memory
    rst_n = 1'b1;
    tick();
    check("boot_req",   32'(imem_bus.imem_req_o), 32'd1);
    check("boot_addr",  imem_bus.imem_addr_o,     32'h0040_0030);
    mem(1'b1, word_of(32'h0040_0030));
    tick();
    check("f0_valid",   32'(if_valid_o),          32'd1);
    check("f0_pc",      if_pc_o,                  32'h0040_0030);
    check("f0_instr",   if_instr_o,               word_of(32'h0040_0030));
    check("f0_plus4",   if_pc_plus4_o,            32'h0040_0034);
    check("f0_addr",    imem_bus.imem_addr_o,     32'h0040_0034);
    mem(1'b1, word_of(32'h0040_0034));
    tick();
    check("f1_pc",      if_pc_o,                  32'h0040_0034);
    check("f1_addr",    imem_bus.imem_addr_o,     32'h0040_0038);

    // Stall while an ack returns -> skid/HOLD
    stall_i = 1'b1;
    mem(1'b1, word_of(32'h0040_0038));
    tick();
    check("hold_req",   32'(imem_bus.imem_req_o), 32'd0);
    check("hold_pc",    if_pc_o,                  32'h0040_0034);
    check("hold_valid", 32'(if_valid_o),          32'd1);
    mem(1'b0, '0);
    tick();
    check("hold2_req",  32'(imem_bus.imem_req_o), 32'd0);
    check("hold2_pc",   if_pc_o,                  32'h0040_0034);
    stall_i = 1'b0;
    tick();
    check("unsk_pc",    if_pc_o,                  32'h0040_0038);
    check("unsk_instr", if_instr_o,               word_of(32'h0040_0038));
    check("unsk_req",   32'(imem_bus.imem_req_o), 32'd1);
    check("unsk_addr",  imem_bus.imem_addr_o,     32'h0040_003C);
    mem(1'b1, word_of(32'h0040_003C));
    tick();
    check("f3_pc",      if_pc_o,                  32'h0040_003C);

    // Redirect while request for 0x40 waits
    mem(1'b0, '0);
    tick();
    check("wait_valid", 32'(if_valid_o),          32'd0);
    check("wait_addr",  imem_bus.imem_addr_o,     32'h0040_0040);
    redirect_i = 1'b1;
    next_pc_i = 32'h0040_0100;
    tick();
    redirect_i = 1'b0;
    check("sq_addr",    imem_bus.imem_addr_o,     32'h0040_0040);
    check("sq_req",     32'(imem_bus.imem_req_o), 32'd1);
    tick();
    check("sq2_addr",   imem_bus.imem_addr_o,     32'h0040_0040);
    mem(1'b1, 32'hDEAD_BEEF);
    tick();
    check("sq_valid",   32'(if_valid_o),          32'd0);
    check("sq_instr",   if_instr_o,               word_of(32'h0040_003C));
    check("sq_next",    imem_bus.imem_addr_o,     32'h0040_0100);

    // Redirect in the same cycle as an ack
    mem(1'b1, word_of(32'h0040_0100));
    redirect_i = 1'b1;
    next_pc_i = 32'h0040_0200;
    tick();
    check("ra_valid",   32'(if_valid_o),          32'd0);
    check("ra_addr",    imem_bus.imem_addr_o,     32'h0040_0200);

    // Wrap-around at the top of the address space
    mem(1'b1, word_of(32'h0040_0200));
    next_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    check("wr_addr0",   imem_bus.imem_addr_o,     32'hFFFF_FFFC);
    mem(1'b1, word_of(32'hFFFF_FFFC));
    tick();
    check("wr_addr1",   imem_bus.imem_addr_o,     32'h0000_0000);
    check("wr_pc",      if_pc_o,                  32'hFFFF_FFFC);
    check("wr_plus4",   if_pc_plus4_o,            32'h0000_0000);
    mem(1'b1, word_of(32'h0000_0000));
    tick();
    check("wr_pc2",     if_pc_o,                  32'h0000_0000);
    check("wr_addr2",   imem_bus.imem_addr_o,     32'h0000_0004);

    // Misaligned redirect
    redirect_i = 1'b1;
    next_pc_i = 32'h0040_0103;
    mem(1'b1, word_of(32'h0000_0004));
    tick();
`ifdef PC_ALIGN_CHECK_EN
    check("mis_addr",   imem_bus.imem_addr_o,     32'h0040_0100);
    check("mis_flag",   32'(fetch_misalign_o),    32'd1);
`else
    check("mis_addr",   imem_bus.imem_addr_o,     32'h0040_0103);
    check("mis_flag",   32'(fetch_misalign_o),    32'd0);
`endif
    next_pc_i = 32'h0040_0200;
    tick();
    redirect_i = 1'b0;
    check("mis_addr2",  imem_bus.imem_addr_o,     32'h0040_0200);
`ifdef PC_ALIGN_CHECK_EN
    check("mis_sticky", 32'(fetch_misalign_o),    32'd1);
`else
    check("mis_sticky", 32'(fetch_misalign_o),    32'd0);
`endif

    // Reset asserted mid-request
    mem(1'b0, '0);
    tick();
    check("mr_req",     32'(imem_bus.imem_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_req",     32'(imem_bus.imem_req_o), 32'd0);
    check("ar_addr",    imem_bus.imem_addr_o,     32'h0040_0030);
    check("ar_valid",   32'(if_valid_o),          32'd0);
    check("ar_mis",     32'(fetch_misalign_o),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
